program_counter: RTL and testbench
==================================

PROGRAM_COUNTER -- requirements
Module: program_counter

Interface
REQ-001: Parameter DATA_WIDTH, default `DATA_WIDTH (8), SHALL set the data bus width; the address width SHALL be 2*DATA_WIDTH (16 by default).
REQ-002: clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003: reset  input  1  reset, synchronous and active-high.
REQ-004: CS  input  1  chip select; gates WE_L, WE_H, INC, OE_L and OE_H.
REQ-005: INC  input  1  increment request.
REQ-006: WE_L  input  1  stage the low byte from the data bus into the shadow register.
REQ-007: WE_H  input  1  take the high byte from the data bus and commit {data, shadow} to the PC.
REQ-008: OE_L  input  1  drive PC low byte onto the data bus.
REQ-009: OE_H  input  1  drive PC high byte onto the data bus.
REQ-010: OE_A  input  1  drive the PC onto the address bus; not gated by CS.
REQ-011: data  inout  DATA_WIDTH  shared data bus; high-Z unless driven by this block.
REQ-012: address  output  2*DATA_WIDTH  address bus; high-Z when OE_A=0.
REQ-013: pc_out  output  2*DATA_WIDTH  current PC value, always driven.
REQ-014: wrap  output  1  registered one-cycle pulse on PC wrap-around.

Function
REQ-015: State SHALL consist of pc (2*DATA_WIDTH), shadow_l (DATA_WIDTH) and wrap (1).
REQ-016: The block SHALL be "driving" when CS & (OE_L | OE_H).
REQ-017: A write SHALL be enabled when CS=1 and the block is not driving; otherwise WE_L, WE_H and INC SHALL be ignored.
REQ-018: If write-enabled and WE_L=1, shadow_l SHALL be loaded with data at the clock edge.
REQ-019: If write-enabled and WE_H=1, pc SHALL be loaded with {data, shadow_l} at the clock edge. shadow_l is its value before that edge, so the jump is atomic and the low byte alone never changes pc.
REQ-020: If write-enabled, WE_H=1 and WE_L=1 in the same cycle, pc SHALL become {data, old shadow_l} and shadow_l SHALL become data.
REQ-021: If write-enabled, INC=1 and WE_H=0, pc SHALL become pc+1 modulo 2^(2*DATA_WIDTH).
REQ-022: When WE_H and INC are both write-enabled, WE_H SHALL win and there SHALL be no increment.
REQ-023: wrap SHALL be 1 in the cycle after an increment from all-ones to zero, and 0 in every other cycle. A WE_H load of zero SHALL NOT set wrap.
REQ-024: When CS & OE_L, data SHALL carry pc[DATA_WIDTH-1:0].
REQ-025: When CS & OE_H & ~OE_L, data SHALL carry pc[2*DATA_WIDTH-1:DATA_WIDTH].
REQ-026: OE_L SHALL take priority over OE_H; the block SHALL never drive both bytes at once.
REQ-027: data SHALL be high-Z in all other cases.
REQ-028: address SHALL equal pc combinationally when OE_A=1, and be high-Z otherwise.
REQ-029: Bus and address outputs SHALL reflect the pc value held in the current cycle; there SHALL be no bypass of same-cycle writes.
REQ-030: pc_out SHALL equal pc at all times.
REQ-031: Write-to-read latency SHALL be 1 cycle: a value committed at edge N is visible on pc_out, address and data from edge N onward.

Reset
REQ-032: reset=1 at a rising edge SHALL set pc=0, shadow_l=0 and wrap=0, overriding WE_L, WE_H and INC in that cycle.
REQ-033: A staged low byte (WE_L with no WE_H yet) SHALL be discarded by reset.
REQ-034: Output drive during reset SHALL still follow REQ-024 to REQ-028, using the current pc value.
REQ-035: No other state SHALL exist, and there SHALL be no asynchronous behaviour.

Verification
REQ-036: Reset, then 3 cycles of CS=1, INC=1 -> pc_out = 0x0003 and wrap = 0 throughout.
REQ-037: WE_L with data=0x34, then 2 idle cycles, then WE_H with data=0x12 -> pc_out stays 0x0000 until the WE_H edge, then reads 0x1234. Then OE_L -> data=0x34; then OE_H -> data=0x12.
REQ-038: Load 0xFFFF, then INC -> pc_out=0x0000 and wrap=1 for exactly one cycle. A following WE_H load of 0x0000 -> wrap=0.
REQ-039: pc=0x00FF, then WE_H with data=0xAB and INC=1 in the same cycle, shadow=0x10 -> pc_out=0xAB10, no increment.
REQ-040: CS=1, OE_L=1, WE_H=1, INC=1 -> pc unchanged and data=pc low byte. CS=0 with INC=1 -> pc unchanged and data high-Z. OE_A=1 with CS=0 -> address=pc.
REQ-041: Stage WE_L with 0x55, assert reset for one cycle, then WE_H with data=0x77 -> pc_out=0x7700.

Source files
------------

// File: rtl/program_counter_if.sv
// Bus-side signals of the program counter: control strobes, shared data bus,
// tri-state address bus and the always-driven PC/wrap status.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

interface program_counter_if #(
  parameter int DATA_WIDTH = `DATA_WIDTH
);
  logic                    CS;
  logic                    INC;
  logic                    WE_L;
  logic                    WE_H;
  logic                    OE_L;
  logic                    OE_H;
  logic                    OE_A;
  wire  [DATA_WIDTH-1:0]   data;
  wire  [2*DATA_WIDTH-1:0] address;
  logic [2*DATA_WIDTH-1:0] pc_out;
  logic                    wrap;

  // Strobes are sampled on the rising clock edge. data is bidirectional:
  // the PC drives it only while CS & (OE_L | OE_H), and accepts writes only
  // when CS is high and it is not itself driving.
  modport slave (
    input  CS, INC, WE_L, WE_H, OE_L, OE_H, OE_A,
    inout  data,
    output address, pc_out, wrap
  );

  modport master (
    output CS, INC, WE_L, WE_H, OE_L, OE_H, OE_A,
    inout  data,
    input  address, pc_out, wrap
  );
endinterface

// File: rtl/program_counter.sv
// Loadable program counter: low byte staged in a shadow register, high-byte
// write commits the full address atomically; tri-state data/address drive.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module program_counter #(
  parameter int DATA_WIDTH = `DATA_WIDTH
) (
  input logic              clk,
  input logic              reset,
  program_counter_if.slave bus
);
  localparam int AW = 2 * DATA_WIDTH;
  localparam logic [AW-1:0] PC_ONE = AW'(1);

  logic [AW-1:0]         pc;
  logic [DATA_WIDTH-1:0] shadow_l;
  logic                  wrap_q;

  logic drive_l;
  logic drive_h;
  logic driving;
  logic write_en;

  // Low byte wins when both output enables are set, so only one byte is
  // ever on the bus. Writes are blocked while this block owns the bus.
  assign drive_l  = bus.CS & bus.OE_L;
  assign drive_h  = bus.CS & bus.OE_H & ~bus.OE_L;
  assign driving  = bus.CS & (bus.OE_L | bus.OE_H);
  assign write_en = bus.CS & ~driving;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= '0;
      shadow_l <= '0;
      wrap_q   <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (write_en && bus.WE_L) begin
        shadow_l <= bus.data;
      end
      // The commit uses the shadow value from before this edge, even when
      // WE_L is also asserted, so a jump never mixes old and new bytes.
      if (write_en && bus.WE_H) begin
        pc <= {bus.data, shadow_l};
      end else if (write_en && bus.INC) begin
        pc     <= pc + PC_ONE;
        wrap_q <= &pc;
      end
    end
  end

  assign bus.data    = drive_l ? pc[DATA_WIDTH-1:0]
                     : (drive_h ? pc[AW-1:DATA_WIDTH] : {DATA_WIDTH{1'bz}});
  assign bus.address = bus.OE_A ? pc : {AW{1'bz}};
  assign bus.pc_out  = pc;
  assign bus.wrap    = wrap_q;
endmodule

// File: tb/tb_program_counter.sv
// Bench for program_counter: directed vector table followed by randomized
// cycles compared against a behavioural model of the PC.
module tb_program_counter;
  localparam int DW = 8;
  localparam int AW = 2 * DW;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  program_counter_if #(.DATA_WIDTH(DW)) bus ();

  program_counter #(.DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Bench-side drivers: the data bus is driven whenever the DUT should not
  // be driving it, and the address bus is held at zero whenever OE_A is low,
  // so any stray drive from the DUT shows up as a wrong read-back value.
  logic [DW-1:0] tb_d;
  logic          tb_d_en;
  logic          tb_a_en;
  assign bus.data    = tb_d_en ? tb_d : {DW{1'bz}};
  assign bus.address = tb_a_en ? {AW{1'b0}} : {AW{1'bz}};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic          rst;
    logic          cs;
    logic          inc;
    logic          wel;
    logic          weh;
    logic          oel;
    logic          oeh;
    logic          oea;
    logic [DW-1:0] d;
    logic [AW-1:0] exp_pc;
    logic          exp_wrap;
    string         name;
  } vec_t;

  // Reference model state
  int unsigned pc_m;
  int unsigned sh_m;
  int unsigned wrap_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, cs, inc, wel, weh, oel, oeh, oea,
                              input logic [DW-1:0] d, input logic [AW-1:0] exp_pc,
                              input logic exp_wrap, input string name);
    vec_t v;
    v.rst = rst; v.cs = cs; v.inc = inc; v.wel = wel; v.weh = weh;
    v.oel = oel; v.oeh = oeh; v.oea = oea; v.d = d;
    v.exp_pc = exp_pc; v.exp_wrap = exp_wrap; v.name = name;
    return v;
  endfunction

  task automatic model_step(input vec_t v);
    bit we;
    int unsigned nsh;
    if (v.rst) begin
      pc_m = 0; sh_m = 0; wrap_m = 0;
      return;
    end
    wrap_m = 0;
    we  = v.cs && !(v.oel || v.oeh);
    nsh = sh_m;
    if (we && v.wel) nsh = v.d;
    if (we && v.weh) begin
      pc_m = v.d * 256 + sh_m;
    end else if (we && v.inc) begin
      pc_m = (pc_m + 1) % 65536;
      if (pc_m == 0) wrap_m = 1;
    end
    sh_m = nsh;
  endtask

  // Applies one cycle of stimulus, checks the combinational bus outputs
  // against the model's current PC, then advances across the clock edge.
  task automatic run_cycle(input vec_t v);
    bit            drv;
    logic [DW-1:0] exp_d;
    logic [AW-1:0] exp_a;
    bus.CS = v.cs; bus.INC = v.inc; bus.WE_L = v.wel; bus.WE_H = v.weh;
    bus.OE_L = v.oel; bus.OE_H = v.oeh; bus.OE_A = v.oea; reset = v.rst;
    drv     = v.cs && (v.oel || v.oeh);
    tb_d    = v.d;
    tb_d_en = !drv;
    tb_a_en = !v.oea;
    #2;
    if (drv) exp_d = v.oel ? DW'(pc_m % 256) : DW'(pc_m / 256);
    else     exp_d = v.d;
    exp_a = v.oea ? AW'(pc_m) : '0;
    chk({v.name, " data"}, 32'(bus.data), 32'(exp_d));
    chk({v.name, " address"}, 32'(bus.address), 32'(exp_a));
    @(posedge clk);
    model_step(v);
    #1;
  endtask

  vec_t vecs[$];

  initial begin
    vec_t v;
    checks = 0; errors = 0;
    pc_m = 0; sh_m = 0; wrap_m = 0;
    reset = 1'b1; tb_d = '0; tb_d_en = 1'b1; tb_a_en = 1'b1;
    bus.CS = 0; bus.INC = 0; bus.WE_L = 0; bus.WE_H = 0;
    bus.OE_L = 0; bus.OE_H = 0; bus.OE_A = 0;
    repeat (2) @(posedge clk);
    #1;

    //            rst cs inc wel weh oel oeh oea  d      pc       wr
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 16'h0000, 0, "reset"));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 8'h00, 16'h0001, 0, "inc1"));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 1, 8'h00, 16'h0002, 0, "inc2"));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 8'h00, 16'h0003, 0, "inc3"));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 16'h0000, 0, "reset2"));
    vecs.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0, 8'h34, 16'h0000, 0, "stage34"));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 8'h99, 16'h0000, 0, "idle1"));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 8'h66, 16'h0000, 0, "idle2_cs0"));
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 8'h12, 16'h1234, 0, "commit12"));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 8'h00, 16'h1234, 0, "read_lo"));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1, 8'h00, 16'h1234, 0, "read_hi"));
    vecs.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0, 8'hFF, 16'h1234, 0, "stageFF"));
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 8'hFF, 16'hFFFF, 0, "loadFFFF"));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 8'h00, 16'h0000, 1, "wrap_inc"));
    vecs.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0, 8'h00, 16'h0000, 0, "wrap_drop"));
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 8'h00, 16'h0000, 0, "load0_nowrap"));
    vecs.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0, 8'hFF, 16'h0000, 0, "stageFF_b"));
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 8'hFF, 16'hFFFF, 0, "loadFFFF_b"));
    vecs.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0, 8'h00, 16'hFFFF, 0, "stage00"));
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 8'h00, 16'h0000, 0, "jump0_nowrap"));
    vecs.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0, 8'hFF, 16'h0000, 0, "stageFF_c"));
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 8'h00, 16'h00FF, 0, "load00FF"));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 1, 8'h00, 16'h0100, 0, "byte_carry"));
    vecs.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0, 8'hFF, 16'h0100, 0, "stageFF_d"));
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 8'h00, 16'h00FF, 0, "load00FF_b"));
    vecs.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0, 8'h10, 16'h00FF, 0, "stage10"));
    vecs.push_back(mk(0, 1, 1, 0, 1, 0, 0, 0, 8'hAB, 16'hAB10, 0, "weh_beats_inc"));
    vecs.push_back(mk(0, 1, 1, 0, 1, 1, 0, 0, 8'h00, 16'hAB10, 0, "oel_blocks_wr"));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 8'h5C, 16'hAB10, 0, "cs0_inc"));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 8'h3B, 16'hAB10, 0, "cs0_oea"));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 1, 0, 8'h00, 16'hAB10, 0, "oel_over_oeh"));
    vecs.push_back(mk(0, 1, 0, 1, 0, 0, 1, 0, 8'h00, 16'hAB10, 0, "oeh_blocks_wel"));
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 8'h01, 16'h0110, 0, "shadow_kept"));
    vecs.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0, 8'h55, 16'h0110, 0, "stage55"));
    vecs.push_back(mk(1, 1, 1, 0, 1, 1, 0, 1, 8'h00, 16'h0000, 0, "reset_drive"));
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 8'h77, 16'h7700, 0, "stage_discarded"));
    vecs.push_back(mk(0, 1, 0, 1, 1, 0, 0, 0, 8'h5A, 16'h5A00, 0, "wel_weh_same"));
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 8'h3C, 16'h3C5A, 0, "new_shadow"));
    vecs.push_back(mk(1, 1, 1, 1, 1, 0, 0, 0, 8'hEE, 16'h0000, 0, "reset_override"));

    foreach (vecs[i]) begin
      run_cycle(vecs[i]);
      chk({vecs[i].name, " pc_out"}, 32'(bus.pc_out), 32'(vecs[i].exp_pc));
      chk({vecs[i].name, " wrap"}, 32'(bus.wrap), 32'(vecs[i].exp_wrap));
    end

    for (int n = 0; n < 400; n++) begin
      v.rst  = ($urandom_range(0, 31) == 0);
      v.cs   = ($urandom_range(0, 3) != 0);
      v.inc  = ($urandom_range(0, 1) == 1);
      v.wel  = ($urandom_range(0, 2) == 0);
      v.weh  = ($urandom_range(0, 3) == 0);
      v.oel  = ($urandom_range(0, 5) == 0);
      v.oeh  = ($urandom_range(0, 5) == 0);
      v.oea  = ($urandom_range(0, 1) == 1);
      v.d    = ($urandom_range(0, 3) == 0) ? 8'hFF : DW'($urandom_range(0, 255));
      v.exp_pc = '0; v.exp_wrap = 1'b0;
      v.name = "rand";
      run_cycle(v);
      chk("rand pc_out", 32'(bus.pc_out), pc_m);
      chk("rand wrap", 32'(bus.wrap), wrap_m);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
